// File: rtl/pixel_write_master.sv
// pixel_write_master: accepts pixel writes from the fractal generator,
// discards out-of-frame addresses and drains the rest through a small FIFO
// onto the frame-buffer SRAM via an Avalon-MM style write master.
module pixel_write_master #(
    parameter logic [31:0] BASE_ADDRESS    = 32'h0000_0000,
    parameter logic [31:0] FRAME_PIXELS    = 32'd307200,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    input  logic [31:0] pixel_address,
    input  logic [7:0]  pixel_data,
    output logic [31:0] master_address,
    output logic        master_write,
    output logic [7:0]  master_writedata,
    input  logic        master_waitrequest,
    output logic [15:0] drop_count,
    output logic        frame_done
);

    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [31:0] LAST_ADDRESS = BASE_ADDRESS + FRAME_PIXELS - 32'd1;
    localparam logic [FIFO_DEPTH_LOG2:0] FULL_COUNT = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0] fifo_address [DEPTH];
    logic [7:0]  fifo_data    [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   count;
    logic [FIFO_DEPTH_LOG2:0]   count_next;

    logic        ready_q;
    logic [31:0] offset;
    logic        in_range;
    logic        accept;
    logic        push;
    logic        pop;

    // Range check is done in unsigned 32-bit arithmetic so addresses below
    // the base wrap to huge offsets; the explicit >= test rejects them anyway.
    assign offset      = pixel_address - BASE_ADDRESS;
    assign in_range    = (pixel_address >= BASE_ADDRESS) && (offset < FRAME_PIXELS);
    assign accept      = pixel_valid && ready_q;
    assign push        = accept && in_range;
    assign pixel_ready = ready_q;

    // Next-state logic: pop the FIFO head whenever the output register is free
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (!master_waitrequest) begin
                    if (count != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Occupancy update; simultaneous push and pop leaves the count alone
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FIFO storage needs no reset; pointers and count define its contents
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_address[wr_ptr] <= pixel_address;
            fifo_data[wr_ptr]    <= pixel_data;
        end
    end

    // FIFO pointers, count and registered ready (derived from next occupancy)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_next;
            ready_q <= (count_next != FULL_COUNT);
        end
    end

    // Bus output registers, held stable while the slave stalls
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            master_address   <= '0;
            master_writedata <= '0;
            master_write     <= 1'b0;
        end else begin
            if (pop) begin
                master_address   <= fifo_address[rd_ptr];
                master_writedata <= fifo_data[rd_ptr];
            end
            master_write <= (state_next == WRITE);
        end
    end

    // Frame completion pulse and saturating discard counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_done <= 1'b0;
            drop_count <= '0;
        end else begin
            frame_done <= (state == WRITE) && !master_waitrequest &&
                          (master_address == LAST_ADDRESS);
            if (accept && !in_range && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/pixel_write_master.md
Name: pixel_write_master

Overview:
- Sits directly downstream of the fractal VGA pixel generator.
- Accepts one (address, colour byte) pixel write at a time through a valid/ready handshake and range-checks it against the frame buffer.
- Buffers in-range writes in a small FIFO and drains them onto the frame-buffer SRAM through an Avalon-MM style write master with waitrequest.
- Out-of-frame writes (e.g. x=640 or y=480 overshoot) are discarded and counted. A pulse marks completion of each frame's last pixel.

Parameters:
- BASE_ADDRESS, 32'h0000_0000, byte address of pixel (0,0) in the frame buffer.
- FRAME_PIXELS, 307200, number of valid pixel addresses (640*480).
- FIFO_DEPTH_LOG2, 2, log2 of FIFO entries (default 4 entries); must be ≥1.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- pixel_valid  input  1  upstream presents a pixel write this cycle.
- pixel_ready  output  1  block can accept a pixel this cycle.
- pixel_address  input  32  absolute byte address of the pixel.
- pixel_data  input  8  RGB332 colour byte.
- master_address  output  32  bus write address.
- master_write  output  1  bus write request.
- master_writedata  output  8  bus write data.
- master_waitrequest  input  1  slave stall; the write completes on an edge where master_write=1 and master_waitrequest=0.
- drop_count  output  16  number of out-of-range pixels discarded; saturating.
- frame_done  output  1  one-cycle pulse when the write to the last frame address completes on the bus.

Behaviour:
- Reset (async, asserted immediately) drives:
  - pixel_ready=0, master_write=0, master_address=0, master_writedata=0, drop_count=0, frame_done=0.
  - FIFO empty; state IDLE.
  - pixel_ready rises in the first cycle after reset deasserts.
- Reset mid-transfer abandons any in-flight write and flushes the FIFO. No completion is reported.
- Input handshake:
  - pixel_ready = !fifo_full (registered status, no combinational path from bus inputs).
  - A transfer occurs on an edge with pixel_valid && pixel_ready.
- Range check, on transfer, 32-bit unsigned: offset = pixel_address - BASE_ADDRESS.
  - In range iff pixel_address >= BASE_ADDRESS and offset < FRAME_PIXELS.
  - In range: push {pixel_address, pixel_data} into the FIFO.
  - Out of range: not pushed; drop_count increments, saturating at 16'hFFFF.
- FIFO:
  - Depth 2^FIFO_DEPTH_LOG2, pointers wrap modulo depth, full/empty tracked with a count.
  - A push and pop on the same edge leave the count unchanged, including when full.
  - No push when full, because ready=0 prevents it.
- Write master FSM:
  - IDLE: if FIFO non-empty, pop head into master_address/master_writedata, set master_write=1, go to WRITE.
  - WRITE: hold master_address, master_writedata and master_write=1 stable while master_waitrequest=1.
  - WRITE, on an edge with waitrequest=0 (write completes):
    - If FIFO non-empty: pop next entry into the output registers, keep master_write=1 and stay in WRITE. Back-to-back writes, one per cycle with no stall.
    - Else: master_write=0, go to IDLE.
- Latency: a pixel accepted into an empty FIFO while IDLE at edge N appears with master_write=1 in the cycle after edge N+1 (2-cycle accept-to-bus).
- frame_done: registered 1-cycle pulse on the edge after a write completes whose master_address == BASE_ADDRESS + FRAME_PIXELS - 1.
- Ordering: bus writes occur in exactly the accepted order; no reordering or merging.
- Throughput: sustained 1 pixel/cycle when waitrequest stays low.

Test Plan:
- Reset then a single pixel (addr 0x0000_0005, data 0x1C) with waitrequest=0 → master_write high for exactly 1 cycle, 2 cycles after acceptance, master_address=5, master_writedata=0x1C; drop_count=0.
- Out-of-range pixels at 307200, 307839 and 0xFFFF_FFFF → no bus writes; drop_count=3; pixel_ready stays 1.
- Hold waitrequest=1, push 6 pixels with valid always high → accepted until FIFO count is 4 plus 1 in the output register. pixel_ready=0 thereafter. Release waitrequest → all 5 written in order, one per cycle, then the sixth is accepted.
- Stream 0..FRAME_PIXELS-1 with random waitrequest → every address written once in order; frame_done pulses exactly once, the cycle after address 307199 completes.
- Assert reset while in WRITE with 3 queued entries → master_write=0 asynchronously; after release, no stale writes appear.
- Force 65540 out-of-range pixels → drop_count saturates at 0xFFFF.
